// File: rtl/eeprom_arbiter_if.sv
// Requester and engine bus of the EEPROM arbiter.
// slave: arbiter side; master: clients + read engine side.
interface eeprom_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_mem_addr;
  logic [8*N_REQ-1:0]  req_nbytes;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    timeout_err;
  logic [7:0]          rx_data;
  logic [N_REQ-1:0]    rx_valid;
  logic [15:0]         eng_mem_addr;
  logic [7:0]          eng_nbytes;
  logic                eng_start;
  logic                eng_abort;
  logic                eng_busy;
  logic [7:0]          eng_data;
  logic                eng_byte_ready;

  modport slave (
    input  req, req_mem_addr, req_nbytes,
    input  eng_busy, eng_data, eng_byte_ready,
    output grant, done, timeout_err,
    output rx_data, rx_valid,
    output eng_mem_addr, eng_nbytes,
    output eng_start, eng_abort
  );

  modport master (
    output req, req_mem_addr, req_nbytes,
    output eng_busy, eng_data, eng_byte_ready,
    input  grant, done, timeout_err,
    input  rx_data, rx_valid,
    input  eng_mem_addr, eng_nbytes,
    input  eng_start, eng_abort
  );
endinterface

// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter sharing one EEPROM read engine among N_REQ clients.
// Ports: clk, rst_n (async low), bus (slave modport: req/grant + engine).
module eeprom_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_LEN = 20
) (
  input logic             clk,
  input logic             rst_n,
  eeprom_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    IDLE, START, RUN, DONE, ABORT
  } state_t;

  state_t st_q, st_d;

  logic [IW-1:0]          ptr_q, ptr_d;
  logic [TIMEOUT_LEN-1:0] wd_q, wd_d, wd_inc;
  logic                   wd_last;
  logic                   br_q;
  logic                   byte_edge;

  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] terr_q, terr_d;
  logic [N_REQ-1:0] rxv_q, rxv_d;
  logic [7:0]       rxd_q, rxd_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       nb_q, nb_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;

  logic          any_req;
  logic [IW-1:0] sel, jj;
  logic [7:0]    sel_nb;
  logic [15:0]   sel_addr;

  assign wd_inc    = wd_q + TIMEOUT_LEN'(1);
  // Next increment lands on all-ones: abort on this edge.
  assign wd_last   = &wd_inc;
  assign byte_edge = bus.eng_byte_ready & ~br_q;

  // Scan from ptr+1 upward with wrap; the lowest offset wins.
  always_comb begin
    any_req = 1'b0;
    sel     = ptr_q;
    jj      = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      jj = IW'((int'(ptr_q) + i) % N_REQ);
      if (bus.req[jj]) begin
        any_req = 1'b1;
        sel     = jj;
      end
    end
  end

  always_comb begin
    sel_nb   = '0;
    sel_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == sel) begin
        sel_nb   = bus.req_nbytes[i*8 +: 8];
        sel_addr = bus.req_mem_addr[i*16 +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      wd_q    <= '0;
      br_q    <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      terr_q  <= '0;
      rxv_q   <= '0;
      rxd_q   <= '0;
      addr_q  <= '0;
      nb_q    <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      br_q    <= bus.eng_byte_ready;
      grant_q <= grant_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      rxv_q   <= rxv_d;
      rxd_q   <= rxd_d;
      addr_q  <= addr_d;
      nb_q    <= nb_d;
      start_q <= start_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (any_req)
          st_d = (sel_nb == 8'd0) ? DONE : START;
      end
      START: begin
        if (wd_last)
          st_d = ABORT;
        else if (bus.eng_busy)
          st_d = RUN;
      end
      RUN: begin
        if (!bus.eng_busy)
          st_d = DONE;
        else if (wd_last)
          st_d = ABORT;
      end
      // Zero-length entry still holds grant: one more cycle for done.
      DONE:    st_d = (|grant_q) ? DONE : IDLE;
      ABORT:   st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    grant_d = grant_q;
    done_d  = '0;
    terr_d  = '0;
    rxv_d   = '0;
    rxd_d   = rxd_q;
    addr_d  = addr_q;
    nb_d    = nb_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (any_req) begin
          grant_d = N_REQ'(1) << sel;
          addr_d  = sel_addr;
          nb_d    = sel_nb;
          ptr_d   = sel;
          wd_d    = '0;
          start_d = (sel_nb != 8'd0);
        end
      end
      START, RUN: begin
        wd_d    = wd_inc;
        start_d = (st_d == START);
        if (st_q == RUN && byte_edge) begin
          rxd_d = bus.eng_data;
          rxv_d = grant_q;
        end
        if (st_d == DONE) begin
          done_d  = grant_q;
          grant_d = '0;
        end
        if (st_d == ABORT) begin
          terr_d  = grant_q;
          abort_d = 1'b1;
          grant_d = '0;
        end
      end
      DONE: begin
        done_d  = grant_q;
        grant_d = '0;
      end
      default: ;
    endcase
  end

  assign bus.grant        = grant_q;
  assign bus.done         = done_q;
  assign bus.timeout_err  = terr_q;
  assign bus.rx_valid     = rxv_q;
  assign bus.rx_data      = rxd_q;
  assign bus.eng_mem_addr = addr_q;
  assign bus.eng_nbytes   = nb_q;
  assign bus.eng_start    = start_q;
  assign bus.eng_abort    = abort_q;
endmodule

// File: doc/eeprom_arbiter.md
# eeprom_arbiter

Round-robin scheduler that shares the single EEPROM read engine, and through it the I2C master, between up to N_REQ requesters. Each requester posts a memory address and byte count. The arbiter grants one requester at a time, pulses the engine start, routes received bytes back to the owner, and signals completion. A watchdog aborts hung transactions. It sits between client logic (LED display, config loaders) and the EEPROM read engine, all in the system clock domain.

## Interface
- N_REQ, 4, number of requesters (2..8)
- TIMEOUT_LEN, 20, watchdog counter width; abort after 2^TIMEOUT_LEN-1 cycles in START+RUN
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous, active-low reset
- req  in  N_REQ  level request per requester; hold high until done or timeout_err
- req_mem_addr  in  16*N_REQ  requester i address at bits [16i+15:16i]
- req_nbytes  in  8*N_REQ  requester i byte count at bits [8i+7:8i]
- grant  out  N_REQ  one-hot current owner
- done  out  N_REQ  one-cycle completion pulse to owner
- timeout_err  out  N_REQ  one-cycle abort pulse to owner
- rx_data  out  8  last received byte
- rx_valid  out  N_REQ  one-cycle pulse to owner when rx_data updates
- eng_mem_addr  out  16  latched address to engine
- eng_nbytes  out  8  latched count to engine
- eng_start  out  1  engine start, held until eng_busy seen
- eng_abort  out  1  one-cycle pulse resetting engine on timeout
- eng_busy  in  1  engine busy
- eng_data  in  8  engine read byte
- eng_byte_ready  in  1  engine byte strobe, rising-edge detected

## Operation
- States: IDLE, START, RUN, DONE, ABORT.
- Reset: state IDLE. All outputs 0. Round-robin pointer = N_REQ-1, so requester 0 has first priority. Byte-ready edge register = 0.
- IDLE, any req high:
  - Select the first set req scanning from pointer+1 upward with wrap.
  - Latch its addr/nbytes into eng_mem_addr/eng_nbytes. Set grant one-hot.
  - Set pointer = selected index. Clear watchdog.
  - If selected nbytes == 0: go to DONE directly, eng_start never asserted. Otherwise go to START.
- START: eng_start=1. When eng_busy sampled 1, go to RUN; eng_start=0 from that edge.
- RUN:
  - A rising edge of eng_byte_ready (registered previous value = 0, current = 1) registers rx_data=eng_data and pulses rx_valid[owner].
  - When eng_busy sampled 0, go to DONE.
- DONE: pulse done[owner] one cycle, clear grant, go to IDLE.
- ABORT: entered from START or RUN when watchdog reaches all-ones. Pulses timeout_err[owner] and eng_abort one cycle, clears grant and eng_start, go to IDLE. Pointer already holds aborted index, so it gets lowest priority next.
- Watchdog increments every cycle in START and RUN. It saturates only via ABORT transition.
- Owner dropping req mid-transaction is ignored; the transaction completes and done still pulses.
- Requests from non-owners are never lost; they wait in IDLE arbitration.
- A requester still holding req in the IDLE cycle after done is re-arbitrated at lowest priority. It is served back-to-back only if no other req is high.
- Byte strobes outside RUN are dropped.
- eng_mem_addr/eng_nbytes are stable from the START entry edge until the next IDLE selection.

## Timing
- All outputs registered.
- req high in IDLE at edge k: grant and eng_start high after edge k; latency 1 cycle.
- eng_busy first sampled 1 at edge m: eng_start low after m; RUN after m.
- eng_byte_ready rising sampled at edge b: rx_valid/rx_data valid after b, for 1 cycle.
- eng_busy sampled 0 at edge d in RUN: done high after d, for 1 cycle, grant 0 same cycle. IDLE after d+1, so next grant after d+2 at earliest.
- nbytes==0: grant after k, done after k+1, zero engine activity.
- Timeout: ABORT entered 2^TIMEOUT_LEN-1 cycles after START entry. timeout_err and eng_abort one cycle. IDLE next.
- Simultaneous busy-low and watchdog max in RUN: DONE wins.
- Simultaneous byte edge and busy-low: byte delivered, rx_valid in the same cycle done is pulsed.
- rst_n low at any time: immediate return to reset values; any in-flight transaction is abandoned without done.

## Test plan
- Single request: req[1]=1, addr 0x0005, nbytes 1. Engine model asserts busy 2 cycles after start, strobes 0xA5, drops busy. Expect grant=0010, rx_valid[1] with rx_data=0xA5, then done[1], eng_mem_addr=0x0005.
- Round-robin fairness: req=1111 held continuously, each transaction re-posted on done. Expect grant order 0,1,2,3,0 with no requester served twice in a row.
- Zero length: req[2]=1, nbytes 0. Expect grant=0100 for one cycle, done[2] the next, eng_start never high.
- Timeout: TIMEOUT_LEN=4, engine never asserts busy. Expect eng_start high 15 cycles, then timeout_err[0] and eng_abort pulses, grant 0, IDLE.
- Multi-byte with mid-op req drop: owner 3, nbytes 3, bytes 0x11/0x22/0x33, req[3] dropped after first byte. Expect three rx_valid[3] pulses in order, then done[3].
- Async reset mid-RUN: rst_n low for 1 ns mid-cycle. Expect all outputs 0 immediately. After release, req=1001 grants requester 0 first.
